// File: rtl/emesh_stream_gen.sv
// emesh_stream_gen: programmable eMesh transaction source feeding ewrapper_link_txo.
//
// Issues a burst of cfg_count reads or writes. The destination address advances by
// (1 << datamode) per accepted transfer and the data follows a deterministic
// sequence starting at cfg_seed. The generator stalls on txo_emesh_wait and can
// insert cfg_gap idle cycles after each accepted transfer.
//
// Optional feature macro: EMESH_GEN_LFSR_EN
//   undefined: data increments by 1 per accepted transfer
//   defined:   data follows a 32-bit Galois LFSR (taps 32,22,2,1), seed 0 -> 1
//
// Ports:
//   txo_lclk, reset_n      clock, asynchronous active-low reset
//   start                  single-cycle pulse, latches cfg_* when idle
//   cfg_*                  burst configuration
//   txo_emesh_wait         back-pressure; holds the presented transfer
//   txo_emesh_*            registered eMesh transaction outputs
//   busy, done, sent_count burst status
module emesh_stream_gen #(
    parameter int unsigned AW = 32,
    parameter int unsigned CW = 16,
    parameter int unsigned GW = 8
) (
    input  logic          txo_lclk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [CW-1:0] cfg_count,
    input  logic [GW-1:0] cfg_gap,
    input  logic          cfg_write,
    input  logic [1:0]    cfg_datamode,
    input  logic [3:0]    cfg_ctrlmode,
    input  logic [AW-1:0] cfg_dstaddr,
    input  logic [AW-1:0] cfg_srcaddr,
    input  logic [AW-1:0] cfg_seed,
    input  logic          txo_emesh_wait,
    output logic          txo_emesh_access,
    output logic          txo_emesh_write,
    output logic [1:0]    txo_emesh_datamode,
    output logic [3:0]    txo_emesh_ctrlmode,
    output logic [AW-1:0] txo_emesh_dstaddr,
    output logic [AW-1:0] txo_emesh_srcaddr,
    output logic [AW-1:0] txo_emesh_data,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] sent_count
);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StFin} state_e;

    state_e        state_q;
    logic [CW-1:0] count_q;
    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_cnt_q;
    logic [AW-1:0] srcaddr_cfg_q;

`ifdef EMESH_GEN_LFSR_EN
    localparam logic [AW-1:0] LfsrTaps = AW'(32'h8020_0003);

    function automatic logic [AW-1:0] first_data(input logic [AW-1:0] seed);
        first_data = (seed == '0) ? AW'(1) : seed;
    endfunction

    function automatic logic [AW-1:0] next_data(input logic [AW-1:0] d);
        next_data = (d >> 1) ^ (d[0] ? LfsrTaps : '0);
    endfunction
`else
    function automatic logic [AW-1:0] first_data(input logic [AW-1:0] seed);
        first_data = seed;
    endfunction

    function automatic logic [AW-1:0] next_data(input logic [AW-1:0] d);
        next_data = d + AW'(1);
    endfunction
`endif

    logic [CW-1:0] sent_next;
    logic [AW-1:0] data_next;
    logic [AW-1:0] seed_data;
    logic          dword_wr;
    logic          cfg_dword_wr;

    always_comb begin
        sent_next    = sent_count + CW'(1);
        data_next    = next_data(txo_emesh_data);
        seed_data    = first_data(cfg_seed);
        dword_wr     = txo_emesh_write && (txo_emesh_datamode == 2'd3);
        cfg_dword_wr = cfg_write && (cfg_datamode == 2'd3);
    end

    // Single registered FSM: every output is a flop, so wait has no comb path out.
    always_ff @(posedge txo_lclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= StIdle;
            count_q            <= '0;
            gap_q              <= '0;
            gap_cnt_q          <= '0;
            srcaddr_cfg_q      <= '0;
            txo_emesh_access   <= 1'b0;
            txo_emesh_write    <= 1'b0;
            txo_emesh_datamode <= 2'd0;
            txo_emesh_ctrlmode <= 4'd0;
            txo_emesh_dstaddr  <= '0;
            txo_emesh_srcaddr  <= '0;
            txo_emesh_data     <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            sent_count         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        count_q            <= cfg_count;
                        gap_q              <= cfg_gap;
                        srcaddr_cfg_q      <= cfg_srcaddr;
                        txo_emesh_write    <= cfg_write;
                        txo_emesh_datamode <= cfg_datamode;
                        txo_emesh_ctrlmode <= cfg_ctrlmode;
                        txo_emesh_dstaddr  <= cfg_dstaddr;
                        txo_emesh_data     <= seed_data;
                        // DWORD writes carry the upper data word in srcaddr
                        txo_emesh_srcaddr  <= cfg_dword_wr ? ~seed_data : cfg_srcaddr;
                        sent_count         <= '0;
                        busy               <= 1'b1;
                        if (cfg_count == '0) begin
                            done    <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            txo_emesh_access <= 1'b1;
                            state_q          <= StSend;
                        end
                    end
                end
                StSend: begin
                    if (!txo_emesh_wait) begin
                        sent_count        <= sent_next;
                        txo_emesh_dstaddr <= txo_emesh_dstaddr + (AW'(1) << txo_emesh_datamode);
                        txo_emesh_data    <= data_next;
                        txo_emesh_srcaddr <= dword_wr ? ~data_next : srcaddr_cfg_q;
                        if (sent_next == count_q) begin
                            txo_emesh_access <= 1'b0;
                            done             <= 1'b1;
                            state_q          <= StFin;
                        end else if (gap_q != '0) begin
                            txo_emesh_access <= 1'b0;
                            gap_cnt_q        <= gap_q;
                            state_q          <= StGap;
                        end
                    end
                end
                StGap: begin
                    // Leave on the last idle cycle so access rises after exactly gap_q idles
                    if (gap_cnt_q == GW'(1)) begin
                        txo_emesh_access <= 1'b1;
                        state_q          <= StSend;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end
                StFin: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/emesh_stream_gen.md
Name: emesh_stream_gen

Overview:
Programmable eMesh transaction source that sits directly upstream of ewrapper_link_txo and drives its txo_emesh_* inputs. It issues a burst of reads or writes with auto-incrementing destination address and a deterministic data pattern, stalls on txo_emesh_wait, and optionally inserts idle gaps between transfers. It replaces file-driven stimulus in link bring-up and provides an on-chip traffic source for elink loopback tests.

Parameters:
AW, 32, address/data width of the eMesh fields (fixed at 32 for eMesh; parameterised for lint only)
CW, 16, width of the transfer-count register
GW, 8, width of the inter-transfer gap counter

Ports:
txo_lclk  in  1  clock, same as ewrapper_link_txo
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; latches config and begins burst
cfg_count  in  CW  number of transfers; 0 = none
cfg_gap  in  GW  idle cycles inserted after each accepted transfer
cfg_write  in  1  1 = writes, 0 = reads
cfg_datamode  in  2  0 BYTE, 1 HWORD, 2 WORD, 3 DWORD
cfg_ctrlmode  in  4  ctrlmode driven on every transfer
cfg_dstaddr  in  AW  first destination address
cfg_srcaddr  in  AW  return address (reads / non-DWORD writes)
cfg_seed  in  AW  data value of first transfer
txo_emesh_wait  in  1  back-pressure from ewrapper_link_txo
txo_emesh_access  out  1  transfer valid
txo_emesh_write  out  1
txo_emesh_datamode  out  2
txo_emesh_ctrlmode  out  4
txo_emesh_dstaddr  out  AW
txo_emesh_srcaddr  out  AW
txo_emesh_data  out  AW
busy  out  1  high from cycle after accepted start until return to IDLE
done  out  1  single-cycle pulse when burst completes
sent_count  out  CW  transfers accepted in current/last burst

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, counters 0.
- States: IDLE, SEND, GAP, FIN.
- IDLE: start=1 latches all cfg_*; if cfg_count==0 -> FIN; else -> SEND with sent_count cleared. start while not IDLE is ignored.
- Latency: start sampled at edge N; txo_emesh_access=1 during cycle N+1.
- SEND: access=1, fields valid. Transfer accepted on edge where access=1 and txo_emesh_wait=0. While wait=1 every output holds stable.
- On acceptance: sent_count+1; dstaddr += (1<<datamode) modulo 2^AW (wrap silently); data += 1 modulo 2^AW. If sent_count+1 == count -> FIN; else if gap!=0 -> GAP (access=0) loaded with gap; else stay SEND (back-to-back, access stays 1).
- GAP: access=0; count down gap cycles then -> SEND. Exactly cfg_gap idle cycles between accepted transfers.
- FIN: access=0, done=1 for one cycle, -> IDLE; busy falls same edge.
- Field rules: write=cfg_write, ctrlmode/datamode constant for burst. srcaddr=cfg_srcaddr except DWORD writes, where srcaddr carries upper data word = ~data (bitwise). Data bits above datamode width driven as generated (receiver ignores them).
- Outputs registered; no combinational path from txo_emesh_wait to any output.
- reset_n asserted mid-burst: immediate return to reset values, burst abandoned, no done pulse.
- Wait asserted in the same cycle a new transfer first presents: transfer held, not lost or duplicated.

Optional Feature:
EMESH_GEN_LFSR_EN: when defined, data sequence is a 32-bit Galois LFSR (taps 32,22,2,1) seeded from cfg_seed (seed 0 replaced by 32'h0000_0001), advanced once per accepted transfer, instead of +1 increment. Without it, data increments by 1. Address behaviour unchanged either way.

Test Plan:
- Reset release, start with count=4, WORD write, dst=0x8000_0000, seed=0x10, gap=0, wait=0 -> four consecutive access cycles beginning cycle after start, dst 0x8000_0000/04/08/0C, data 0x10..0x13, done pulse one cycle after 4th, sent_count=4.
- Same burst, wait held high 3 cycles on 2nd transfer -> 2nd transfer fields stable across all wait cycles, exactly 4 transfers accepted, no duplicates.
- count=3, BYTE read, gap=2, dst=0xFFFF_FFFE -> access pattern 1,0,0,1,0,0,1; dst 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 (wrap); write=0; srcaddr=cfg_srcaddr.
- DWORD write count=2, seed=0x1234_5678 -> data 0x1234_5678 srcaddr 0xEDCB_A987, then data 0x1234_5679 srcaddr 0xEDCB_A986; dst step 8.
- count=0 start -> no access, done pulse 1 cycle after start; second start pulse while busy during long burst -> ignored, sent_count equals first count.
- reset_n low mid-burst after 2 of 5 transfers -> access drops asynchronously, no done pulse, new start afterwards runs full burst from cfg values.
